// File: rtl/lrn_pkg.sv
// Shared types and helpers for the LRN window buffer.
package lrn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PRIME,
        ST_UPDATE,
        ST_OFFER,
        ST_WAIT_DIV
    } lrn_wb_state_t;

    // A window of local_size squares of data_width-bit signed samples.
    function automatic int sumsq_width(input int data_width, input int local_size);
        return 2 * data_width + $clog2(local_size + 1);
    endfunction

endpackage

// File: rtl/lrn_window_buffer_if.sv
// Read-return, sum-of-squares stream and divider-return signals of the window buffer.
interface lrn_window_buffer_if
    import lrn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = sumsq_width(16, 5)
);
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  sq_out_valid;
    logic                  sq_out_ready;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic [SUM_WIDTH-1:0]  sumsq_out;
    logic                  div_out_valid;

    // Memory / divider side.
    modport master (
        output rd_valid, rd_data, sq_out_ready, div_out_valid,
        input  sq_out_valid, pixel_out, sumsq_out
    );

    // Window buffer side.
    modport slave (
        input  rd_valid, rd_data, sq_out_ready, div_out_valid,
        output sq_out_valid, pixel_out, sumsq_out
    );
endinterface

// File: rtl/lrn_chan_ram.sv
// Channel sample store: one synchronous write port, two asynchronous read ports
// so the add and subtract terms of the sliding window are read together.
module lrn_chan_ram #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 6
) (
    input  logic                  core_clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr_a,
    output logic [DATA_WIDTH-1:0] o_rd_data_a,
    input  logic [AW-1:0]         i_rd_addr_b,
    output logic [DATA_WIDTH-1:0] o_rd_data_b
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_wr_in_range;
    logic w_a_in_range;
    logic w_b_in_range;

    assign w_wr_in_range = {1'b0, i_wr_addr}   < DEPTH_W;
    assign w_a_in_range  = {1'b0, i_rd_addr_a} < DEPTH_W;
    assign w_b_in_range  = {1'b0, i_rd_addr_b} < DEPTH_W;

    assign o_rd_data_a = w_a_in_range ? r_mem[i_rd_addr_a] : '0;
    assign o_rd_data_b = w_b_in_range ? r_mem[i_rd_addr_b] : '0;

    // Sample write; contents need no reset since every pixel refills them.
    always_ff @(posedge core_clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end
endmodule

// File: rtl/lrn_window_buffer.sv
// LRN window buffer: captures one pixel's channel vector, streams each channel
// with its cross-channel sum of squares, and tracks returning divider results.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for start_normalization with a legal dim3
// ST_FILL     | capturing read returns into the channel buffer
// ST_PRIME    | accumulating the first HALF squares of the window
// ST_UPDATE   | slide window by one channel, register the output pair
// ST_OFFER    | pair held on the stream until the divider accepts it
// ST_WAIT_DIV | all pairs sent, waiting for the remaining divider results
module lrn_window_buffer
    import lrn_pkg::*;
#(
    parameter int M_WIDTH    = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_CH     = 64,
    parameter int LOCAL_SIZE = 5,
    parameter int SUM_WIDTH  = sumsq_width(DATA_WIDTH, LOCAL_SIZE)
) (
    input  logic               core_clk,
    input  logic               reset,
    input  logic               start_normalization,
    input  logic               normalized_layer,
    input  logic [M_WIDTH-1:0] dim3,
    output logic               full_flag,
    output logic               normalized_window,
    output logic               err,
    lrn_window_buffer_if.slave bus
);
    localparam int HALF = LOCAL_SIZE / 2;
    localparam int AW   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
    localparam int IW   = M_WIDTH + 1;
    localparam int SQW  = 2 * DATA_WIDTH;

    localparam logic [IW-1:0]      MAX_CH_W = IW'(MAX_CH);
    localparam logic [IW-1:0]      HALF_W   = IW'(HALF);
    localparam logic [IW-1:0]      HALF_P1  = IW'(HALF + 1);
    localparam logic [M_WIDTH-1:0] HALF_M1  = M_WIDTH'((HALF > 0) ? HALF - 1 : 0);

    lrn_wb_state_t         r_state;
    logic [M_WIDTH-1:0]    r_dim;
    logic [M_WIDTH-1:0]    r_fill_cnt;
    logic [M_WIDTH-1:0]    r_prime_k;
    logic [M_WIDTH-1:0]    r_c;
    logic [M_WIDTH-1:0]    r_div_cnt;
    logic [SUM_WIDTH-1:0]  r_sum;
    logic [DATA_WIDTH-1:0] r_pix_next;
    logic                  r_full;
    logic                  r_sq_valid;
    logic [DATA_WIDTH-1:0] r_pixel;
    logic [SUM_WIDTH-1:0]  r_sumsq;
    logic                  r_nw;
    logic                  r_err;

    logic [AW-1:0]         w_addr_a;
    logic [AW-1:0]         w_addr_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_wr_en;
    logic signed [SQW-1:0] w_ext_a;
    logic signed [SQW-1:0] w_ext_b;
    logic signed [SQW-1:0] w_prod_a;
    logic signed [SQW-1:0] w_prod_b;
    logic [SUM_WIDTH-1:0]  w_sq_a;
    logic [SUM_WIDTH-1:0]  w_sq_b;
    logic                  w_add_ok;
    logic                  w_sub_ok;
    logic [SUM_WIDTH-1:0]  w_sum_upd;
    logic                  w_dim_ok;
    logic                  w_fill_last;
    logic                  w_c_last;
    logic                  w_div_window;
    logic                  w_div_accept;
    logic                  w_div_bad;
    logic                  w_rd_bad;
    logic [M_WIDTH-1:0]    w_div_cnt_nxt;

    assign w_wr_en = bus.rd_valid && (r_state == ST_FILL) && !normalized_layer;

    lrn_chan_ram #(
        .DEPTH      (MAX_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_chan_ram (
        .core_clk    (core_clk),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (AW'(r_fill_cnt)),
        .i_wr_data   (bus.rd_data),
        .i_rd_addr_a (w_addr_a),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (w_addr_b),
        .o_rd_data_b (w_rd_b)
    );

    // Port A: priming term or the channel entering the window.
    always_comb begin
        w_addr_a = AW'(r_c) + AW'(HALF);
        if (r_state == ST_PRIME) begin
            w_addr_a = AW'(r_prime_k);
        end
    end

    // Port B: channel leaving the window in UPDATE, otherwise the next pixel to offer.
    always_comb begin
        w_addr_b = '0;
        case (r_state)
            ST_UPDATE: w_addr_b = AW'(r_c) - AW'(HALF + 1);
            ST_OFFER:  w_addr_b = AW'(r_c) + AW'(1);
            default:   w_addr_b = '0;
        endcase
    end

    // Squares taken on sign-extended operands; the product is never negative.
    assign w_ext_a  = {{DATA_WIDTH{w_rd_a[DATA_WIDTH-1]}}, w_rd_a};
    assign w_ext_b  = {{DATA_WIDTH{w_rd_b[DATA_WIDTH-1]}}, w_rd_b};
    assign w_prod_a = w_ext_a * w_ext_a;
    assign w_prod_b = w_ext_b * w_ext_b;
    assign w_sq_a   = {{(SUM_WIDTH-SQW){1'b0}}, w_prod_a};
    assign w_sq_b   = {{(SUM_WIDTH-SQW){1'b0}}, w_prod_b};

    assign w_add_ok  = ({1'b0, r_c} + HALF_W) < {1'b0, r_dim};
    assign w_sub_ok  = {1'b0, r_c} >= HALF_P1;
    assign w_sum_upd = r_sum + (w_add_ok ? w_sq_a : '0) - (w_sub_ok ? w_sq_b : '0);

    assign w_dim_ok    = (dim3 != '0) && ({1'b0, dim3} <= MAX_CH_W);
    assign w_fill_last = ({1'b0, r_fill_cnt} + 1'b1) == {1'b0, r_dim};
    assign w_c_last    = ({1'b0, r_c} + 1'b1) == {1'b0, r_dim};

    assign w_div_window  = (r_state == ST_UPDATE) || (r_state == ST_OFFER) ||
                           (r_state == ST_WAIT_DIV);
    assign w_div_accept  = bus.div_out_valid && w_div_window && (r_div_cnt != r_dim);
    assign w_div_bad     = bus.div_out_valid && !w_div_accept;
    assign w_rd_bad      = bus.rd_valid && (r_state != ST_FILL);
    assign w_div_cnt_nxt = r_div_cnt + {{(M_WIDTH-1){1'b0}}, w_div_accept};

    // Main sequencer: state, counters, running sum and all registered outputs.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dim      <= '0;
            r_fill_cnt <= '0;
            r_prime_k  <= '0;
            r_c        <= '0;
            r_div_cnt  <= '0;
            r_sum      <= '0;
            r_pix_next <= '0;
            r_full     <= 1'b0;
            r_sq_valid <= 1'b0;
            r_pixel    <= '0;
            r_sumsq    <= '0;
            r_nw       <= 1'b0;
            r_err      <= 1'b0;
        end else if (normalized_layer) begin
            // Layer done overrides everything; the error flag survives it.
            r_state    <= ST_IDLE;
            r_fill_cnt <= '0;
            r_prime_k  <= '0;
            r_c        <= '0;
            r_div_cnt  <= '0;
            r_sum      <= '0;
            r_pix_next <= '0;
            r_full     <= 1'b0;
            r_sq_valid <= 1'b0;
            r_pixel    <= '0;
            r_sumsq    <= '0;
            r_nw       <= 1'b0;
        end else begin
            r_nw <= 1'b0;
            if (w_div_accept) begin
                r_div_cnt <= w_div_cnt_nxt;
            end
            if (w_div_bad || w_rd_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_normalization) begin
                        if (w_dim_ok) begin
                            r_dim      <= dim3;
                            r_fill_cnt <= '0;
                            r_state    <= ST_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (bus.rd_valid) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (w_fill_last) begin
                            r_full    <= 1'b1;
                            r_prime_k <= '0;
                            r_c       <= '0;
                            // Channel 0 is the first pixel offered; with one channel it is this very sample.
                            r_pix_next <= (r_fill_cnt == '0) ? bus.rd_data : w_rd_b;
                            if (HALF > 0) begin
                                r_state <= ST_PRIME;
                            end else begin
                                r_state <= ST_UPDATE;
                            end
                        end
                    end
                end
                ST_PRIME: begin
                    if (r_prime_k < r_dim) begin
                        r_sum <= r_sum + w_sq_a;
                    end
                    r_prime_k <= r_prime_k + 1'b1;
                    if (r_prime_k == HALF_M1) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_sum      <= w_sum_upd;
                    r_sumsq    <= w_sum_upd;
                    r_pixel    <= r_pix_next;
                    r_sq_valid <= 1'b1;
                    r_state    <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (bus.sq_out_ready) begin
                        r_sq_valid <= 1'b0;
                        if (w_c_last) begin
                            r_state <= ST_WAIT_DIV;
                        end else begin
                            r_c        <= r_c + 1'b1;
                            r_pix_next <= w_rd_b;
                            r_state    <= ST_UPDATE;
                        end
                    end
                end
                ST_WAIT_DIV: begin
                    if (w_div_cnt_nxt == r_dim) begin
                        r_nw       <= 1'b1;
                        r_full     <= 1'b0;
                        r_fill_cnt <= '0;
                        r_prime_k  <= '0;
                        r_c        <= '0;
                        r_div_cnt  <= '0;
                        r_sum      <= '0;
                        r_state    <= ST_FILL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign full_flag         = r_full;
    assign normalized_window = r_nw;
    assign err               = r_err;
    assign bus.sq_out_valid  = r_sq_valid;
    assign bus.pixel_out     = r_pixel;
    assign bus.sumsq_out     = r_sumsq;
endmodule

// File: doc/lrn_window_buffer.md
Name: lrn_window_buffer

Overview:
- Read-data side of the LRN mapper handshake. Captures the dim3 channel samples of one pixel as memory returns them, then asserts full_flag.
- Computes the cross-channel local sum of squares for each channel with a sliding window, and streams {pixel, sum_sq} pairs to the divider.
- Counts divider results and pulses normalized_window when all dim3 results for the pixel have returned.

Parameters:
- M_WIDTH, 10, width of dim3.
- DATA_WIDTH, 16, sample width (signed two's complement).
- MAX_CH, 64, channel buffer depth; dim3 must be in 1..MAX_CH.
- LOCAL_SIZE, 5, LRN window size; odd, ≥1. HALF = LOCAL_SIZE/2.
- SUM_WIDTH, 2*DATA_WIDTH+$clog2(LOCAL_SIZE+1), width of the sum-of-squares output.

Ports:
- core_clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start_normalization  in  1  level/pulse; IDLE→FILL.
- normalized_layer  in  1  layer complete; any state→IDLE.
- dim3  in  M_WIDTH  channel count; sampled at start.
- rd_valid  in  1  rd_data valid (memory read return).
- rd_data  in  DATA_WIDTH  read sample.
- full_flag  out  1  pixel's channel vector fully captured.
- sq_out_valid  out  1  pair offered to divider.
- sq_out_ready  in  1  divider accepts.
- pixel_out  out  DATA_WIDTH  buf[c].
- sumsq_out  out  SUM_WIDTH  S(c).
- div_out_valid  in  1  one divider result returned.
- normalized_window  out  1  one-cycle pulse, pixel complete.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and the running sum S = 0. Buffer contents are don't-care.
- S(c) = Σ buf[k]² for k in [c−HALF, c+HALF] ∩ [0, dim3−1]. Squares are computed unsigned at 2*DATA_WIDTH bits; S never overflows SUM_WIDTH.
- States: IDLE, FILL, PRIME, UPDATE, OFFER, WAIT_DIV.
- IDLE:
  - start_normalization with 1 ≤ dim3 ≤ MAX_CH → latch dim3, go to FILL.
  - If dim3 is out of range, ignore start, set err, stay in IDLE.
- FILL:
  - Each rd_valid writes buf[fill_cnt] and increments fill_cnt.
  - On the write of index dim3−1: full_flag = 1 from the next cycle, go to PRIME.
  - full_flag holds until the normalized_window cycle.
- PRIME:
  - Adds buf[k]² for k = 0..min(HALF, dim3)−1, one term per cycle (HALF cycles, 0 when HALF = 0), then go to UPDATE with c = 0.
- UPDATE (1 cycle):
  - S += buf[c+HALF]² if c+HALF < dim3.
  - S −= buf[c−HALF−1]² if c−HALF−1 ≥ 0.
  - Go to OFFER.
- OFFER:
  - sq_out_valid = 1; pixel_out and sumsq_out are registered and stable while valid.
  - On valid & ready: if c = dim3−1, go to WAIT_DIV; else c++ and go to UPDATE.
  - Valid never drops without ready.
- Divider results:
  - div_cnt increments on every div_out_valid in UPDATE, OFFER or WAIT_DIV.
  - div_out_valid in any other state, or after div_cnt = dim3, sets err and is not counted.
- WAIT_DIV: when div_cnt = dim3, in the same cycle:
  - normalized_window = 1 for one cycle, full_flag = 0;
  - fill_cnt, c, div_cnt and S are cleared;
  - next state is FILL (next pixel).
  - Also applies when the final div_out_valid arrives in the same cycle as entry.
- rd_valid outside FILL sets err and the data is dropped.
- normalized_layer in any state:
  - next cycle state is IDLE; counters, S and all outputs cleared; err retained.
  - Takes priority over every other event in that cycle.
- start_normalization outside IDLE is ignored.
- Latency for dim3 = D, with no backpressure:
  - last rd_valid → full_flag: 1 cycle;
  - full_flag → first sq_out_valid: HALF+1 cycles;
  - steady state: one pair every 2 cycles.

Decomposition:
- Package lrn_pkg:
  - state enum lrn_wb_state_t;
  - function sumsq_width(DATA_WIDTH, LOCAL_SIZE).
- Sub-module lrn_chan_ram: MAX_CH×DATA_WIDTH register file, 1 write port plus 2 asynchronous read ports (add term, subtract term), so UPDATE completes in 1 cycle.

Test Plan:
- Basic window:
  - Stimulus: LOCAL_SIZE=3, dim3=4, rd_data 1,2,3,4, sq_out_ready=1.
  - Response: full_flag 1 cycle after the 4th sample; pairs (1,5), (2,14), (3,29), (4,25); then 4 div_out_valid → single normalized_window pulse and full_flag low in the same cycle.
- Signed and edge sizes:
  - dim3=1, rd_data −3: pair (−3, 9).
  - LOCAL_SIZE=5, dim3=2, data 2,−1: (2,5), (−1,5).
- Backpressure:
  - Basic window with sq_out_ready low for 3 cycles on c=1.
  - sq_out_valid stays high with (2,14) stable; no duplicate or skipped pair.
- Divider interleave:
  - div_out_valid arriving during OFFER of c=2 and c=3, plus 2 more in WAIT_DIV.
  - normalized_window on the 4th result only; a 5th div_out_valid sets err.
- Abort and errors:
  - normalized_layer asserted mid-OFFER → state IDLE, all outputs 0 next cycle, a new start works.
  - rd_valid during WAIT_DIV → err=1, buffer unchanged.
  - start with dim3=0 → stays IDLE, err=1.
- Back-to-back pixels:
  - Two pixels, second rd_valid burst arriving 1 cycle after normalized_window.
  - Correct second set of sums; S starts from 0.
